fp_unit_arbiter: RTL and testbench

- Shares one FPUnit (add/mul, multi-cycle, Start/Busy handshake) between two requesters: Req0 is the CPU execute stage and Req1 is a coprocessor/DMA-side client.
- Arbitrates between them round-robin, latches the winner's operands and op, issues a one-cycle FP_Start, and waits for FP_Busy to fall.
- Returns the result with a one-cycle Done pulse to the owning requester.
- A watchdog aborts hung operations.

---
 rtl/fp_unit_arbiter.sv | 148 ++++++++++++++
 tb/tb_fp_unit_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_unit_arbiter.sv
// Purpose: round-robin arbiter sharing one multi-cycle FPUnit between two requesters, with a watchdog abort.
// Latency: grant +1 cycle to FP_Start, Done one cycle after FP_Busy falls (or after TIMEOUT WAIT cycles).
// Backpressure: requesters hold Valid until their Done pulse; one op in flight, no grant is evaluated in RESP.
module fp_unit_arbiter #(
  parameter int width   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Req0_Valid,
  input  logic             Req0_Op,
  input  logic [width-1:0] Req0_A,
  input  logic [width-1:0] Req0_B,
  output logic             Req0_Done,
  input  logic             Req1_Valid,
  input  logic             Req1_Op,
  input  logic [width-1:0] Req1_A,
  input  logic [width-1:0] Req1_B,
  output logic             Req1_Done,
  output logic [width-1:0] Result,
  output logic             Error,
  output logic             Owner,
  output logic             FP_Start,
  output logic             FPUnitOp,
  output logic [width-1:0] FP_Operand1,
  output logic [width-1:0] FP_Operand2,
  input  logic [width-1:0] FP_Result,
  input  logic             FP_Busy
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [width-1:0] QNAN = width'(32'h7FC00000);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state_q;
  logic             last_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             timeout_d;
  logic             done0_q;
  logic             done1_q;
  logic [width-1:0] result_q;
  logic             error_q;
  logic             owner_q;
  logic             start_q;
  logic             op_q;
  logic [width-1:0] opnd1_q;
  logic [width-1:0] opnd2_q;

  logic             grant_vld_d;
  logic             grant_idx_d;
  logic             grant_op_d;
  logic [width-1:0] grant_a_d;
  logic [width-1:0] grant_b_d;

  // Round-robin pick: a lone requester wins, on contention the one not served last wins.
  always_comb begin
    grant_vld_d = Req0_Valid | Req1_Valid;
    grant_idx_d = Req1_Valid;
    if (Req0_Valid && Req1_Valid) begin
      grant_idx_d = ~last_q;
    end
    grant_op_d = grant_idx_d ? Req1_Op : Req0_Op;
    grant_a_d  = grant_idx_d ? Req1_A  : Req0_A;
    grant_b_d  = grant_idx_d ? Req1_B  : Req0_B;
  end

  // Watchdog: next count and the abort condition on the last allowed WAIT cycle.
  always_comb begin
    cnt_d     = cnt_q + 1'b1;
    timeout_d = (cnt_q == CW'(TIMEOUT - 1));
  end

  // Arbitration / issue / wait / respond sequencer with registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      cnt_q    <= '0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      result_q <= '0;
      error_q  <= 1'b0;
      owner_q  <= 1'b0;
      start_q  <= 1'b0;
      op_q     <= 1'b0;
      opnd1_q  <= '0;
      opnd2_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_vld_d) begin
            owner_q <= grant_idx_d;
            op_q    <= grant_op_d;
            opnd1_q <= grant_a_d;
            opnd2_q <= grant_b_d;
            start_q <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          // FP_Busy may still be low here, so it is not looked at until WAIT.
          start_q <= 1'b0;
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_d;
          if (!FP_Busy) begin
            result_q <= FP_Result;
            error_q  <= 1'b0;
            done0_q  <= ~owner_q;
            done1_q  <= owner_q;
            state_q  <= RESP;
          end else if (timeout_d) begin
            result_q <= QNAN;
            error_q  <= 1'b1;
            done0_q  <= ~owner_q;
            done1_q  <= owner_q;
            state_q  <= RESP;
          end
        end
        RESP: begin
          // Done is visible this cycle; the requester gets it to drop Valid before IDLE.
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          last_q  <= owner_q;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Req0_Done   = done0_q;
  assign Req1_Done   = done1_q;
  assign Result      = result_q;
  assign Error       = error_q;
  assign Owner       = owner_q;
  assign FP_Start    = start_q;
  assign FPUnitOp    = op_q;
  assign FP_Operand1 = opnd1_q;
  assign FP_Operand2 = opnd2_q;

endmodule

// File: tb/tb_fp_unit_arbiter.sv
// Bench for fp_unit_arbiter: behavioural FPUnit, two requester drivers, scoreboard + monitor.
// Expected completions are queued in service order when stimulus is planned; the monitor pops on every Done.
// All waits on the DUT are bounded; an expired bound is reported as a miscompare.
module tb_fp_unit_arbiter;
  localparam int W  = 32;
  localparam int TO = 8;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          r_valid [0:1];
  logic          r_op    [0:1];
  logic [W-1:0]  r_a     [0:1];
  logic [W-1:0]  r_b     [0:1];
  logic          Req0_Done, Req1_Done, Error, Owner, FP_Start, FPUnitOp;
  logic          FP_Busy;
  logic [W-1:0]  Result, FP_Operand1, FP_Operand2, FP_Result;

  int vectors = 0;
  int misc    = 0;
  int cyc     = 0;
  int issue_cyc = 0;
  int n_start = 0;
  logic hang = 1'b0;
  int fpu_cnt;

  typedef struct {
    logic        owner;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb_q[$];

  logic        lst_op [0:1][0:15];
  logic [31:0] lst_a  [0:1][0:15];
  logic [31:0] lst_b  [0:1][0:15];

  fp_unit_arbiter #(.width(W), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RESET(RESET),
    .Req0_Valid(r_valid[0]), .Req0_Op(r_op[0]), .Req0_A(r_a[0]), .Req0_B(r_b[0]), .Req0_Done(Req0_Done),
    .Req1_Valid(r_valid[1]), .Req1_Op(r_op[1]), .Req1_A(r_a[1]), .Req1_B(r_b[1]), .Req1_Done(Req1_Done),
    .Result(Result), .Error(Error), .Owner(Owner),
    .FP_Start(FP_Start), .FPUnitOp(FPUnitOp),
    .FP_Operand1(FP_Operand1), .FP_Operand2(FP_Operand2),
    .FP_Result(FP_Result), .FP_Busy(FP_Busy)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // IEEE single <-> real for normal values; results used here are exact in single precision.
  function automatic real sp2r(input logic [31:0] x);
    logic [63:0] d;
    logic [10:0] e;
    if (x[30:0] == 31'd0) return 0.0;
    e = {3'b000, x[30:23]} + 11'd896;
    d = {x[31], e, x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fp_calc(input logic op, input logic [31:0] a, input logic [31:0] b);
    return op ? r2sp(sp2r(a) * sp2r(b)) : r2sp(sp2r(a) + sp2r(b));
  endfunction

  function automatic logic [31:0] int2sp(input int k);
    real r;
    r = k;
    return r2sp(r);
  endfunction

  // Behavioural FPUnit: Busy rises the cycle after Start, stays 1..5 cycles (or forever when hung).
  always @(posedge CLK) begin
    if (RESET) begin
      FP_Busy   <= 1'b0;
      FP_Result <= '0;
      fpu_cnt   <= 0;
    end else if (FP_Start) begin
      FP_Busy <= 1'b1;
      fpu_cnt <= int'($urandom_range(5, 1));
    end else if (FP_Busy && !hang) begin
      if (fpu_cnt <= 1) begin
        FP_Busy   <= 1'b0;
        FP_Result <= fp_calc(FPUnitOp, FP_Operand1, FP_Operand2);
      end else begin
        fpu_cnt <= fpu_cnt - 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      misc++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic push(input logic owner, input logic op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] res, input logic err, input int lat);
    exp_t e;
    e.owner = owner; e.op = op; e.a = a; e.b = b; e.res = res; e.err = err; e.lat = lat;
    sb_q.push_back(e);
  endtask

  task automatic push_model(input logic owner, input logic op, input logic [31:0] a, input logic [31:0] b);
    push(owner, op, a, b, fp_calc(op, a, b), 1'b0, 0);
  endtask

  // Monitor: every Done pops the oldest expected completion and compares it.
  exp_t m_e;
  logic prev_start = 1'b0;
  always @(negedge CLK) begin
    if (!RESET) begin
      if (FP_Start) begin
        issue_cyc = cyc;
        n_start++;
        chk("start_single_cycle", 32'(prev_start), 32'd0);
      end
      prev_start = FP_Start;
      if (Req0_Done || Req1_Done) begin
        if (sb_q.size() == 0) begin
          vectors++;
          misc++;
          $display("FAIL unexpected_done: got Req0_Done=%0b Req1_Done=%0b, required none", Req0_Done, Req1_Done);
        end else begin
          m_e = sb_q.pop_front();
          chk("done_exclusive", 32'(Req0_Done & Req1_Done), 32'd0);
          chk("done_owner",     32'(Req1_Done), 32'(m_e.owner));
          chk("owner_out",      32'(Owner),     32'(m_e.owner));
          chk("result",         Result,         m_e.res);
          chk("error",          32'(Error),     32'(m_e.err));
          chk("operand1",       FP_Operand1,    m_e.a);
          chk("operand2",       FP_Operand2,    m_e.b);
          chk("unit_op",        32'(FPUnitOp),  32'(m_e.op));
          if (m_e.lat > 0) chk("done_latency", 32'(cyc - issue_cyc), 32'(m_e.lat));
        end
      end
    end
  end

  task automatic wait_done(input int r);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge CLK);
      if ((r == 0) ? Req0_Done : Req1_Done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      vectors++;
      misc++;
      $display("FAIL done_wait req%0d: no Done in 200 cycles, required one", r);
    end
  endtask

  task automatic wait_start();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge CLK);
      if (FP_Start) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      vectors++;
      misc++;
      $display("FAIL start_wait: no FP_Start in 50 cycles, required one");
    end
  endtask

  // Requester driver: presents each listed op and holds Valid until its Done.
  task automatic drive(input int r, input int n);
    for (int i = 0; i < n; i++) begin
      r_valid[r] = 1'b1;
      r_op[r]    = lst_op[r][i];
      r_a[r]     = lst_a[r][i];
      r_b[r]     = lst_b[r][i];
      wait_done(r);
    end
    r_valid[r] = 1'b0;
  endtask

  task automatic rand_op(input int r, input int i);
    lst_op[r][i] = 1'($urandom_range(1, 0));
    lst_a[r][i]  = int2sp(int'($urandom_range(1000, 1)));
    lst_b[r][i]  = int2sp(int'($urandom_range(1000, 1)));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_result"},   Result,              32'd0);
    chk({tag, "_error"},    32'(Error),          32'd0);
    chk({tag, "_owner"},    32'(Owner),          32'd0);
    chk({tag, "_start"},    32'(FP_Start),       32'd0);
    chk({tag, "_done"},     32'({Req1_Done, Req0_Done}), 32'd0);
    chk({tag, "_opnd1"},    FP_Operand1,         32'd0);
    chk({tag, "_unitop"},   32'(FPUnitOp),       32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int s0;
    RESET = 1'b1;
    for (int r = 0; r < 2; r++) begin
      r_valid[r] = 1'b0; r_op[r] = 1'b0; r_a[r] = '0; r_b[r] = '0;
    end
    repeat (3) @(negedge CLK);
    chk_reset_outputs("reset");
    RESET = 1'b0;
    repeat (2) @(negedge CLK);

    // Single Req0 add 48 + 5.
    s0 = n_start;
    push(1'b0, 1'b0, 32'h42400000, 32'h40A00000, 32'h42540000, 1'b0, 0);
    lst_op[0][0] = 1'b0; lst_a[0][0] = 32'h42400000; lst_b[0][0] = 32'h40A00000;
    drive(0, 1);
    chk("t1_start_count", 32'(n_start - s0), 32'd1);
    repeat (2) @(negedge CLK);

    // Single Req1 mul 48 * 5.
    push(1'b1, 1'b1, 32'h42400000, 32'h40A00000, 32'h43700000, 1'b0, 0);
    lst_op[1][0] = 1'b1; lst_a[1][0] = 32'h42400000; lst_b[1][0] = 32'h40A00000;
    drive(1, 1);
    repeat (2) @(negedge CLK);

    // Both valid together, held continuously: grants alternate 0,1,0,1.
    lst_op[0][0] = 1'b0; lst_a[0][0] = 32'h42C80000; lst_b[0][0] = 32'h43480000;
    lst_op[1][0] = 1'b1; lst_a[1][0] = 32'h42C80000; lst_b[1][0] = 32'h43480000;
    rand_op(0, 1);
    rand_op(1, 1);
    push(1'b0, 1'b0, 32'h42C80000, 32'h43480000, 32'h43960000, 1'b0, 0);
    push(1'b1, 1'b1, 32'h42C80000, 32'h43480000, 32'h469C4000, 1'b0, 0);
    push_model(1'b0, lst_op[0][1], lst_a[0][1], lst_b[0][1]);
    push_model(1'b1, lst_op[1][1], lst_a[1][1], lst_b[1][1]);
    fork
      drive(0, 2);
      drive(1, 2);
    join
    repeat (2) @(negedge CLK);

    // Randomized contention: both requesters stream 6 ops each; service alternates from Req0.
    for (int i = 0; i < 6; i++) begin
      for (int r = 0; r < 2; r++) begin
        rand_op(r, i);
        push_model(1'(r), lst_op[r][i], lst_a[r][i], lst_b[r][i]);
      end
    end
    fork
      drive(0, 6);
      drive(1, 6);
    join
    repeat (2) @(negedge CLK);

    // Hung FPUnit: watchdog aborts, Done 9 cycles after ISSUE with quiet NaN and Error.
    hang = 1'b1;
    lst_op[0][0] = 1'b1; lst_a[0][0] = int2sp(3); lst_b[0][0] = int2sp(4);
    push(1'b0, 1'b1, int2sp(3), int2sp(4), 32'h7FC00000, 1'b1, TO + 1);
    drive(0, 1);
    hang = 1'b0;
    repeat (2) @(negedge CLK);
    chk("error_holds", 32'(Error), 32'd1);

    // Following normal op clears Error.
    rand_op(1, 0);
    push_model(1'b1, lst_op[1][0], lst_a[1][0], lst_b[1][0]);
    drive(1, 1);
    repeat (2) @(negedge CLK);

    // Reset during WAIT: op dropped, no Done, outputs back to reset values.
    r_valid[1] = 1'b1; r_op[1] = 1'b1; r_a[1] = int2sp(7); r_b[1] = int2sp(9);
    wait_start();
    @(negedge CLK);
    RESET = 1'b1;
    r_valid[1] = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    chk_reset_outputs("midreset");
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      chk("midreset_idle_start", 32'(FP_Start), 32'd0);
    end

    // Fresh Req1 request after reset is granted normally.
    rand_op(1, 0);
    push_model(1'b1, lst_op[1][0], lst_a[1][0], lst_b[1][0]);
    drive(1, 1);
    repeat (2) @(negedge CLK);

    // Owner drops Valid mid-op and both requesters scramble operands: in-flight op unaffected.
    r_valid[0] = 1'b1; r_op[0] = 1'b0; r_a[0] = int2sp(111); r_b[0] = int2sp(222);
    push(1'b0, 1'b0, int2sp(111), int2sp(222), int2sp(333), 1'b0, 0);
    wait_start();
    @(negedge CLK);
    r_valid[0] = 1'b0;
    r_op[0] = 1'b1; r_a[0] = $urandom; r_b[0] = $urandom;
    r_op[1] = 1'b1; r_a[1] = $urandom; r_b[1] = $urandom;
    @(negedge CLK);
    chk("hold_opnd1", FP_Operand1, int2sp(111));
    chk("hold_opnd2", FP_Operand2, int2sp(222));
    wait_done(0);
    repeat (4) @(negedge CLK);

    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end

endmodule
